// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and pointer width helper.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [ptr_w(FIFO_DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [ptr_w(FIFO_DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]          rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO, standard or first-word-fall-through read.
// Sticky overflow/underflow flags built only with PARAM_SYNC_FIFO_ERR_EN.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FIFO_STD
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         rd_en,
  input  logic                         flush,
  input  logic                         clr_err,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [ptr_w(FIFO_DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = ptr_w(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (int'(cnt) >= AF_LEVEL);
  assign almost_empty = (int'(cnt) <= AE_LEVEL);
  assign count        = cnt;

  // flush wins over both ports, so nothing is accepted that cycle
  assign wr_acc = wr_en & ~full & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        wr_acc & ~rd_acc: cnt <= cnt + CW'(1);
        rd_acc & ~wr_acc: cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  fifo_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign dout       = empty ? '0 : rdata;
    assign dout_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dv_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dout_q <= '0;
        dv_q   <= 1'b0;
      end else begin
        dv_q <= rd_acc;
        if (rd_acc) dout_q <= rdata;
      end
    end

    assign dout       = dout_q;
    assign dout_valid = dv_q;
  end

`ifdef PARAM_SYNC_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr_err) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en & full)  ovf_q <= 1'b1;
      if (rd_en & empty) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: depth-4 standard and FWFT instances.
module tb_param_sync_fifo;
  import fifo_pkg::*;

`ifdef PARAM_SYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic       wr0, rd0, fl0, clr0;
  logic [7:0] din0, dout0;
  logic       dv0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [2:0] cnt0;

  logic       wr1, rd1, fl1, clr1;
  logic [7:0] din1, dout1;
  logic       dv1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0] cnt1;

  param_sync_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .AF_LEVEL(3),
    .AE_LEVEL(1), .FWFT(FIFO_STD)
  ) u0 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr0), .din(din0), .rd_en(rd0),
    .flush(fl0), .clr_err(clr0),
    .dout(dout0), .dout_valid(dv0),
    .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0),
    .count(cnt0),
    .overflow(ovf0), .underflow(unf0)
  );

  param_sync_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(4), .FWFT(FIFO_FWFT)
  ) u1 (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr1), .din(din1), .rd_en(rd1),
    .flush(fl1), .clr_err(clr1),
    .dout(dout1), .dout_valid(dv1),
    .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1),
    .count(cnt1),
    .overflow(ovf1), .underflow(unf1)
  );

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       fl;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic w, logic [7:0] d, logic r,
                              logic f, int c, logic fu, logic em,
                              logic a_f, logic a_e, logic ov,
                              logic un);
    vec_t v;
    v.wr = w; v.din = d; v.rd = r; v.fl = f; v.cnt = c;
    v.full = fu; v.empty = em; v.af = a_f; v.ae = a_e;
    v.ovf = ov; v.unf = un;
    return v;
  endfunction

  // one clock on u0 with the reference queue model alongside
  task automatic step0(input string tag, input logic w,
                       input logic [7:0] d, input logic r,
                       input logic f, input logic c);
    logic acc_w, acc_r, exp_dv;
    acc_w = w && (mq.size() < 4);
    acc_r = r && (mq.size() > 0);
    exp_dv = acc_r && !f;
    if (f) mq.delete();
    else begin
      if (acc_r) sb.push_back(mq.pop_front());
      if (acc_w) mq.push_back(d);
    end
    wr0 = w; din0 = d; rd0 = r; fl0 = f; clr0 = c;
    @(posedge clk);
    #1;
    wr0 = 0; rd0 = 0; fl0 = 0; clr0 = 0;
    chk({tag, " dv"}, 32'(dv0), 32'(exp_dv));
    if (exp_dv) begin
      if (sb.size() == 0) chk({tag, " sb"}, 32'(0), 32'(1));
      else chk({tag, " dout"}, 32'(dout0), 32'(sb.pop_front()));
    end
  endtask

  task automatic step1(input logic w, input logic [7:0] d,
                       input logic r);
    wr1 = w; din1 = d; rd1 = r;
    @(posedge clk);
    #1;
    wr1 = 0; rd1 = 0;
  endtask

  initial begin
    wr0 = 0; rd0 = 0; fl0 = 0; clr0 = 0; din0 = 0;
    wr1 = 0; rd1 = 0; fl1 = 0; clr1 = 0; din1 = 0;
    reset_n = 0;

    vt.push_back(mk(1, 8'h11, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(1, 8'h22, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 8'h33, 0, 0, 3, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 8'h44, 0, 0, 4, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 8'h55, 0, 0, 4, 1, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 3, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 2, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 0));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 1));
    vt.push_back(mk(1, 8'hAA, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    vt.push_back(mk(1, 8'hBB, 0, 0, 2, 0, 0, 0, 0, 1, 1));
    for (int k = 0; k < 10; k++)
      vt.push_back(mk(1, 8'hC0 + 8'(k), 1, 0, 2, 0, 0, 0, 0, 1, 1));
    vt.push_back(mk(1, 8'hD0, 0, 0, 3, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(1, 8'hD1, 0, 0, 4, 1, 0, 1, 0, 1, 1));
    vt.push_back(mk(1, 8'hD2, 1, 0, 3, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(1, 8'hE1, 0, 1, 0, 0, 1, 0, 1, 1, 1));
    vt.push_back(mk(1, 8'hE0, 1, 0, 1, 0, 0, 0, 1, 1, 1));
    vt.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 1));

    #2;
    chk("rst cnt", 32'(cnt0), 32'(0));
    chk("rst empty", 32'(empty0), 32'(1));
    chk("rst full", 32'(full0), 32'(0));
    chk("rst af", 32'(af0), 32'(0));
    chk("rst ae", 32'(ae0), 32'(1));
    chk("rst dv", 32'(dv0), 32'(0));
    chk("rst dout", 32'(dout0), 32'(0));
    chk("rst ovf", 32'(ovf0), 32'(0));
    chk("rst unf", 32'(unf0), 32'(0));
    chk("rst fwft dv", 32'(dv1), 32'(0));
    chk("rst fwft empty", 32'(empty1), 32'(1));
    #1 reset_n = 1;

    foreach (vt[i]) begin
      string t;
      t = $sformatf("r%0d", i);
      step0(t, vt[i].wr, vt[i].din, vt[i].rd, vt[i].fl, 1'b0);
      chk({t, " cnt"}, 32'(cnt0), 32'(vt[i].cnt));
      chk({t, " full"}, 32'(full0), 32'(vt[i].full));
      chk({t, " empty"}, 32'(empty0), 32'(vt[i].empty));
      chk({t, " af"}, 32'(af0), 32'(vt[i].af));
      chk({t, " ae"}, 32'(ae0), 32'(vt[i].ae));
      chk({t, " ovf"}, 32'(ovf0), 32'(vt[i].ovf & ERR));
      chk({t, " unf"}, 32'(unf0), 32'(vt[i].unf & ERR));
    end

    // clear has priority over a same-cycle underflow
    step0("clr", 0, 8'h00, 1, 0, 1);
    chk("clr ovf", 32'(ovf0), 32'(0));
    chk("clr unf", 32'(unf0), 32'(0));
    step0("unf2", 0, 8'h00, 1, 0, 0);
    chk("unf2 unf", 32'(unf0), 32'(ERR));
    chk("unf2 ovf", 32'(ovf0), 32'(0));

    step1(1, 8'hA5, 0);
    chk("fwft dout", 32'(dout1), 32'h0A5);
    chk("fwft dv", 32'(dv1), 32'(1));
    chk("fwft empty", 32'(empty1), 32'(0));
    step1(0, 8'h00, 0);
    chk("fwft hold", 32'(dout1), 32'h0A5);
    step1(0, 8'h00, 1);
    chk("fwft pop empty", 32'(empty1), 32'(1));
    chk("fwft pop dv", 32'(dv1), 32'(0));
    step1(1, 8'h5A, 0);
    step1(1, 8'h6B, 0);
    chk("fwft cnt2", 32'(cnt1), 32'(2));
    chk("fwft head", 32'(dout1), 32'h05A);
    step1(0, 8'h00, 1);
    chk("fwft next", 32'(dout1), 32'h06B);
    step1(0, 8'h00, 1);
    chk("fwft drain", 32'(empty1), 32'(1));

    step0("b0", 1, 8'h71, 0, 0, 0);
    step0("b1", 1, 8'h72, 0, 0, 0);
    step0("b2", 1, 8'h73, 1, 0, 0);
    reset_n = 0;
    #2;
    chk("arst cnt", 32'(cnt0), 32'(0));
    chk("arst empty", 32'(empty0), 32'(1));
    chk("arst ae", 32'(ae0), 32'(1));
    chk("arst full", 32'(full0), 32'(0));
    chk("arst af", 32'(af0), 32'(0));
    chk("arst dv", 32'(dv0), 32'(0));
    chk("arst dout", 32'(dout0), 32'(0));
    chk("arst unf", 32'(unf0), 32'(0));
    mq.delete();
    sb.delete();
    reset_n = 1;
    step0("post0", 1, 8'h77, 0, 0, 0);
    chk("post cnt", 32'(cnt0), 32'(1));
    step0("post1", 0, 8'h00, 1, 0, 0);
    chk("post empty", 32'(empty0), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
